// File: rtl/dispense_sequencer_if.sv
// Control/status bundle between the drink front end and the dispense sequencer.
interface dispense_sequencer_if;
    logic       start;
    logic [1:0] drink;
    logic       cup_present;
    logic       temp_ok;
    logic       cancel;
    logic       fault_clr;
    logic       heater_on;
    logic [3:0] valve;
    logic       pump_on;
    logic       mixer_on;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output start, drink, cup_present, temp_ok, cancel, fault_clr,
        input  heater_on, valve, pump_on, mixer_on, busy, done, fault,
        input  fault_code
    );

    modport slave (
        input  start, drink, cup_present, temp_ok, cancel, fault_clr,
        output heater_on, valve, pump_on, mixer_on, busy, done, fault,
        output fault_code
    );
endinterface

// File: rtl/dispense_sequencer.sv
// Timed heater/powder/pump/mixer sequencer with cup and boiler supervision.
// Moore outputs; counter restarts on every state change.
module dispense_sequencer #(
    parameter int CNT_W      = 8,
    parameter int T_HEAT_MAX = 200,
    parameter int T_POWDER   = 8,
    parameter int T_WATER    = 32,
    parameter int T_MIX      = 16
) (
    input logic                  clk,
    input logic                  reset,
    dispense_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAT,
        S_POWDER,
        S_WATER,
        S_MIX,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] HEAT_LAST   = CNT_W'(T_HEAT_MAX - 1);
    localparam logic [CNT_W-1:0] POWDER_LAST = CNT_W'(T_POWDER - 1);
    localparam logic [CNT_W-1:0] WATER_LAST  = CNT_W'(T_WATER - 1);
    localparam logic [CNT_W-1:0] WATER2_LAST = CNT_W'(2 * T_WATER - 1);
    localparam logic [CNT_W-1:0] MIX_LAST    = CNT_W'(T_MIX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       drink_q, drink_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] water_last;

    assign water_last = (drink_q == 2'd3) ? WATER2_LAST : WATER_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drink_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drink_q <= drink_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        drink_d = drink_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    if (bus.cup_present) begin
                        state_d = S_HEAT;
                        drink_d = bus.drink;
                    end else begin
                        state_d = S_FAULT;
                        code_d  = 2'b01;
                    end
                end
            end
            S_HEAT: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (bus.temp_ok) begin
                    state_d = S_POWDER;
                end else if (cnt_q == HEAT_LAST) begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                end
            end
            S_POWDER: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (!bus.cup_present) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end else if (cnt_q == POWDER_LAST) begin
                    state_d = S_WATER;
                end
            end
            S_WATER: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (!bus.cup_present) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end else if (cnt_q == water_last) begin
                    state_d = S_MIX;
                end
            end
            S_MIX: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (!bus.cup_present) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end else if (cnt_q == MIX_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                cnt_d = '0;
                if (bus.fault_clr) begin
                    state_d = S_IDLE;
                    code_d  = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = 2'b00;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        bus.heater_on  = 1'b0;
        bus.valve      = 4'b0000;
        bus.pump_on    = 1'b0;
        bus.mixer_on   = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.fault      = 1'b0;
        bus.fault_code = code_q;
        unique case (state_q)
            S_HEAT: begin
                bus.heater_on = 1'b1;
                bus.busy      = 1'b1;
            end
            S_POWDER: begin
                bus.valve = 4'b0001 << drink_q;
                bus.busy  = 1'b1;
            end
            S_WATER: begin
                bus.pump_on   = 1'b1;
                bus.heater_on = 1'b1;
                bus.busy      = 1'b1;
            end
            S_MIX: begin
                bus.mixer_on = 1'b1;
                bus.busy     = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
            end
            S_FAULT: begin
                bus.fault = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
Timed sequencer for the beverage dispensing datapath. It sits downstream of the selection/payment state machines. Once a validated drink request arrives, it drives the heater, the powder valves, the pump and the mixer through fixed phases. It also supervises the cup sensor and the water temperature, and reports completion or a fault to the front panel logic.

Parameters:
CNT_W, 8, width of the phase counter; must hold 2*T_WATER and T_HEAT_MAX
T_HEAT_MAX, 200, max cycles spent in HEAT waiting for temp_ok before timeout fault
T_POWDER, 8, cycles the selected powder valve stays open
T_WATER, 32, pump cycles for drinks 0-2; drink 3 (long) uses 2*T_WATER
T_MIX, 16, mixer cycles

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-high; forces IDLE immediately
start  in  1  one-cycle request from selection FSM; sampled only in IDLE
drink  in  2  drink code, latched into drink_q when start is accepted
cup_present  in  1  cup sensor, 1 = cup under nozzle
temp_ok  in  1  boiler at temperature
cancel  in  1  user abort
fault_clr  in  1  operator acknowledge, leaves FAULT
heater_on  out  1  heater enable
valve  out  4  one-hot powder valve, bit index = drink_q
pump_on  out  1  water pump
mixer_on  out  1  mixer motor
busy  out  1  high in HEAT, POWDER, WATER, MIX, DONE
done  out  1  one-cycle completion pulse
fault  out  1  high while in FAULT
fault_code  out  2  00 none, 01 no cup / cup removed, 10 heat timeout; held in FAULT

Behaviour:
- Moore outputs decoded from the registered state; all outputs 0, state IDLE, counter 0 and drink_q 0 while reset is high and directly after it.
- States: IDLE, HEAT, POWDER, WATER, MIX, DONE, FAULT. The phase counter clears on every state change.
- IDLE:
  - start=1 and cup_present=1: latch drink, go to HEAT at the next edge.
  - start=1 and cup_present=0: go to FAULT, code 01.
  - Otherwise stay.
- HEAT:
  - heater_on=1; counter increments each cycle.
  - temp_ok=1: go to POWDER. The minimum dwell is 1 cycle.
  - temp_ok=0 with counter==T_HEAT_MAX-1: go to FAULT, code 10.
- POWDER: valve[drink_q]=1 for exactly T_POWDER cycles, then WATER.
- WATER: pump_on=1 and heater_on=1 for T_WATER cycles, or 2*T_WATER when drink_q==3; then MIX.
- MIX: mixer_on=1 for T_MIX cycles, then DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- FAULT:
  - All actuators are off.
  - fault_code holds until fault_clr=1, which returns to IDLE and clears fault_code to 00.
  - start and cancel are ignored in FAULT.
- Priority in busy states, highest first:
  1. cancel: go to IDLE, no done pulse.
  2. cup_present=0 in POWDER, WATER or MIX: go to FAULT, code 01.
  3. Phase completion or heat timeout.
- A new start while busy is ignored; drink_q is not overwritten.
- Reset asserted mid-phase turns all actuators off asynchronously. The state after reset release is IDLE.
- The counter never wraps. Legal parameter sets satisfy T_HEAT_MAX, 2*T_WATER, T_POWDER, T_MIX <= 2^CNT_W - 1.
- Latency: start sampled at edge 0 → heater_on high from edge 1. With temp_ok already high, the total is 1 + T_POWDER + T_WATER + T_MIX cycles before DONE.

Test Plan:
1. Defaults, temp_ok=1, cup_present=1, drink=1, start pulse at edge 0 → HEAT at edge 1, valve=0010 for edges 2-9, pump_on edges 10-41, mixer_on edges 42-57, done=1 at edge 58, busy=0 at edge 59.
2. drink=3, otherwise as test 1 → pump_on for 64 cycles (edges 10-73), done at edge 90, valve=1000 in POWDER.
3. temp_ok held 0 after start at edge 0 → heater_on for 200 cycles, fault=1 with fault_code=10 at edge 201; fault_clr at edge 205 → IDLE at edge 206 with fault_code=00.
4. start with cup_present=0 → FAULT with code 01 next cycle. Also: cup_present dropped at edge 20 (WATER) → pump_on=0 and fault=1 from edge 21, done never pulses.
5. cancel and cup_present=0 asserted together at edge 30 → IDLE at edge 31 with fault=0, all outputs 0, no done. A start pulse at edge 15 (mid-run) is ignored and drink_q is unchanged.
6. reset asserted between edges in MIX → mixer_on and busy drop immediately without a clock edge. After release, start at the next edge begins a fresh HEAT.
